spi_poll_sequencer: RTL
=======================

Name: spi_poll_sequencer

Overview:
Schedules periodic 4-byte SPI transactions for the SPI controller that sits directly downstream of it, and collects the bytes that controller returns. It drives the controller's request and command bytes, watches the SPI slave-select line to detect the start and end of each frame, and packs the four received bytes into one 32-bit sample. The sample goes out on a valid/ready interface. It also reports overrun and timeout conditions.

Parameters:
PERIOD, 1000, poll interval in clk cycles, measured from one request assertion to the next; legal range 16..2^20-1.
TIMEOUT, 4096, maximum clk cycles to wait for a slave-select edge before aborting.
CAPTURE_DLY, 2, clk cycles between the detected slave-select rising edge and the capture of the received bytes; minimum 1.

Ports:
clk  in  1  system clock
n_rst  in  1  asynchronous active-low reset
enable  in  1  level; while high, polls are issued every PERIOD cycles
clear_flags  in  1  one-cycle pulse; clears the overrun and timeout_err flags
cmd_0 .. cmd_3  in  8 each  command bytes; held in registers at each request
ctrl_en  out  1  request to the SPI controller
word_0_in .. word_3_in  out  8 each  registered command bytes presented to the controller
ss_in  in  1  slave-select from the SPI controller, active low
word_0_out .. word_3_out  in  8 each  bytes received by the SPI controller
sample_data  out  32  {word_0_out, word_1_out, word_2_out, word_3_out}; word_0_out occupies the MSB byte
sample_valid  out  1  sample available
sample_ready  in  1  consumer accepts the sample
busy  out  1  high in every state except IDLE
overrun  out  1  sticky; a sample was dropped
timeout_err  out  1  sticky; a transaction was aborted

Behaviour:
- Clock and reset:
  - Single clock domain: clk.
  - Reset n_rst is asynchronous and active-low; every register clears immediately on assertion.
- Reset values: ctrl_en=0, word_N_in=0x00, sample_data=0, sample_valid=0, busy=0, overrun=0, timeout_err=0, all counters=0, state=IDLE.
- Reset mid-operation: ctrl_en drops asynchronously. Nothing is captured. The downstream controller is reset by the same n_rst.
- ss_in is in the clk domain and needs no synchroniser. It is registered once for edge detection:
  - falling edge = previous 1, current 0
  - rising edge = previous 0, current 1
- States:
  - IDLE: if enable=1, copy cmd_0..3 into word_0..3_in, set ctrl_en=1, clear the period and timeout counters, go to REQUEST.
  - REQUEST: ctrl_en held high.
    - On an ss_in falling edge: ctrl_en=0, timeout counter cleared, go to ACTIVE. This prevents a second frame.
    - If the timeout counter reaches TIMEOUT-1 first: ctrl_en=0, timeout_err=1, go to WAIT_PERIOD.
  - ACTIVE:
    - On an ss_in rising edge: go to CAPTURE.
    - On timeout: timeout_err=1, go to WAIT_PERIOD, no capture.
  - CAPTURE: count CAPTURE_DLY cycles, then load the output register or drop the sample (see below), then go to WAIT_PERIOD.
  - WAIT_PERIOD:
    - When the period counter is >= PERIOD-1 and enable=1: issue the next request exactly as IDLE does.
    - If enable=0: go to IDLE.
    - If the frame took longer than PERIOD, the next request is issued on the cycle after CAPTURE.
- Period counter: free-runs from the request cycle and saturates at PERIOD-1.
- enable deasserted mid-frame: the current frame completes and is captured, then the block goes to IDLE.
- Output register (valid/ready):
  - A transfer occurs on a cycle where sample_valid=1 and sample_ready=1; sample_valid clears on the next edge.
  - sample_data is stable while sample_valid=1.
  - Capture when the register is empty, or on the same cycle as a transfer: load sample_data and set sample_valid=1.
  - Capture when sample_valid=1 and sample_ready=0: drop the new sample, keep the old one, set overrun=1.
- Latency: sample_valid rises CAPTURE_DLY+1 cycles after the cycle in which ss_in is sampled high.
- Flags:
  - clear_flags clears overrun and timeout_err.
  - If a set condition and clear_flags occur in the same cycle, the set wins.
- busy: high in REQUEST, ACTIVE, CAPTURE and WAIT_PERIOD.

Test Plan:
1. Basic capture. Stimulus: reset, enable=1, cmd=0xA1,B2,C3,D4; slave returns 0x11,22,33,44; sample_ready=1. Required: word_N_in equal the cmd bytes at request; sample_data=0x11223344 and sample_valid high for 1 cycle, CAPTURE_DLY+1 cycles after ss_in rises; ctrl_en low after the ss_in falling edge.
2. Periodic polling. Stimulus: PERIOD=200, enable held high for 5 frames. Required: consecutive ctrl_en rising edges exactly 200 cycles apart; 5 samples delivered; no frame starts while ss_in=0.
3. Backpressure and overrun. Stimulus: sample_ready=0 across 2 frames with data 0x01020304 then 0x05060708. Required: sample_data remains 0x01020304; overrun=1; after clear_flags, overrun=0.
4. Timeout. Stimulus: ss_in tied high, TIMEOUT=64. Required: ctrl_en is high for 64 cycles then low; timeout_err=1; no sample_valid; next request issued at PERIOD.
5. Mid-operation events. Stimulus: deassert enable during ACTIVE; later, assert n_rst low during REQUEST. Required: first case delivers the frame, then busy=0 in IDLE; second case gives ctrl_en=0 and sample_valid=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/spi_poll_sequencer_if.sv
// Sample output bundle of the SPI poll sequencer.
// Valid/ready handshake carrying one packed 32-bit sample.
interface spi_poll_sequencer_if;
  logic [31:0] sample_data;
  logic        sample_valid;
  logic        sample_ready;

  modport master (
    output sample_data,
    output sample_valid,
    input  sample_ready
  );

  modport slave (
    input  sample_data,
    input  sample_valid,
    output sample_ready
  );
endinterface

// File: rtl/spi_poll_sequencer.sv
// Periodic 4-byte SPI poll scheduler: requests frames from the SPI
// controller, tracks slave-select, packs returned bytes into samples.
module spi_poll_sequencer #(
  parameter int PERIOD      = 1000,
  parameter int TIMEOUT     = 4096,
  parameter int CAPTURE_DLY = 2
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       enable,
  input  logic       clear_flags,
  input  logic [7:0] cmd_0,
  input  logic [7:0] cmd_1,
  input  logic [7:0] cmd_2,
  input  logic [7:0] cmd_3,
  output logic       ctrl_en,
  output logic [7:0] word_0_in,
  output logic [7:0] word_1_in,
  output logic [7:0] word_2_in,
  output logic [7:0] word_3_in,
  input  logic       ss_in,
  input  logic [7:0] word_0_out,
  input  logic [7:0] word_1_out,
  input  logic [7:0] word_2_out,
  input  logic [7:0] word_3_out,
  spi_poll_sequencer_if.master smp,
  output logic       busy,
  output logic       overrun,
  output logic       timeout_err
);

  localparam int PW = $clog2(PERIOD + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int CW = $clog2(CAPTURE_DLY + 1);

  localparam logic [PW-1:0] PER_MAX = PW'(PERIOD - 1);
  localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CAP_MAX = CW'(CAPTURE_DLY - 1);

  typedef enum logic [2:0] {
    IDLE,
    REQUEST,
    ACTIVE,
    CAPTURE,
    WAIT_PERIOD
  } state_t;

  state_t state_q;
  state_t state_d;

  logic          ss_q;
  logic          ss_fall;
  logic          ss_rise;
  logic [PW-1:0] per_cnt;
  logic [TW-1:0] to_cnt;
  logic [CW-1:0] cap_cnt;
  logic          per_done;
  logic          to_hit;
  logic          cap_done;
  logic          issue;
  logic          abort;
  logic          cap_fire;
  logic [31:0]   data_q;
  logic          valid_q;
  logic          xfer;
  logic          drop;

  assign ss_fall  = ss_q & ~ss_in;
  assign ss_rise  = ~ss_q & ss_in;
  assign per_done = (per_cnt == PER_MAX);
  assign to_hit   = (to_cnt == TO_MAX);
  assign cap_done = (cap_cnt == CAP_MAX);

  assign xfer = valid_q & smp.sample_ready;
  assign drop = cap_fire & valid_q & ~smp.sample_ready;

  // Decoded from state so reset drops the request with no clock edge.
  assign ctrl_en = (state_q == REQUEST);
  assign busy    = (state_q != IDLE);

  assign smp.sample_data  = data_q;
  assign smp.sample_valid = valid_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    issue    = 1'b0;
    abort    = 1'b0;
    cap_fire = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enable) begin
          issue   = 1'b1;
          state_d = REQUEST;
        end
      end
      REQUEST: begin
        if (ss_fall) begin
          state_d = ACTIVE;
        end else if (to_hit) begin
          abort   = 1'b1;
          state_d = WAIT_PERIOD;
        end
      end
      ACTIVE: begin
        if (ss_rise) begin
          state_d = CAPTURE;
        end else if (to_hit) begin
          abort   = 1'b1;
          state_d = WAIT_PERIOD;
        end
      end
      CAPTURE: begin
        if (cap_done) begin
          cap_fire = 1'b1;
          state_d  = WAIT_PERIOD;
        end
      end
      WAIT_PERIOD: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (per_done) begin
          issue   = 1'b1;
          state_d = REQUEST;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ss_q <= 1'b0;
    end else begin
      ss_q <= ss_in;
    end
  end

  // Period runs from the request cycle and parks at its terminal value.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      per_cnt <= '0;
    end else if (issue) begin
      per_cnt <= '0;
    end else if (busy && !per_done) begin
      per_cnt <= per_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      to_cnt <= '0;
    end else if (issue) begin
      to_cnt <= '0;
    end else if (state_q == REQUEST && ss_fall) begin
      to_cnt <= '0;
    end else if ((state_q == REQUEST || state_q == ACTIVE) && !to_hit) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cap_cnt <= '0;
    end else if (state_q != CAPTURE) begin
      cap_cnt <= '0;
    end else if (!cap_done) begin
      cap_cnt <= cap_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      word_0_in <= 8'h00;
      word_1_in <= 8'h00;
      word_2_in <= 8'h00;
      word_3_in <= 8'h00;
    end else if (issue) begin
      word_0_in <= cmd_0;
      word_1_in <= cmd_1;
      word_2_in <= cmd_2;
      word_3_in <= cmd_3;
    end
  end

  // A capture that coincides with a transfer refills the register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (cap_fire && (!valid_q || smp.sample_ready)) begin
      data_q  <= {word_0_out, word_1_out, word_2_out, word_3_out};
      valid_q <= 1'b1;
    end else if (xfer) begin
      valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      overrun <= 1'b0;
    end else if (drop) begin
      overrun <= 1'b1;
    end else if (clear_flags) begin
      overrun <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      timeout_err <= 1'b0;
    end else if (abort) begin
      timeout_err <= 1'b1;
    end else if (clear_flags) begin
      timeout_err <= 1'b0;
    end
  end

endmodule
